// File: rtl/spi_ram_pkg.sv
// ==== spi_ram_pkg: shared command/state types and address helper | rev 1.0 ====
`default_nettype none

package spi_ram_pkg;

    typedef enum logic [1:0] {
        CMD_WR_ADDR = 2'b00,
        CMD_WR_DATA = 2'b01,
        CMD_RD_ADDR = 2'b10,
        CMD_RD_DATA = 2'b11
    } cmd_e;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Explicit compare against depth-1 so non power-of-two depths wrap correctly.
    function automatic int unsigned next_addr(input int unsigned addr, input int unsigned depth);
        return (addr == depth - 32'd1) ? 32'd0 : addr + 32'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/spi_ram_array.sv
// ==== spi_ram_array: MEM_DEPTH x DATA_W RAM, one sync write and one sync read port | rev 1.0 ====
`default_nettype none

module spi_ram_array #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8,
    parameter int MEM_DEPTH = 256
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem [MEM_DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/spi_ram_ctrl_p.sv
// ==== spi_ram_ctrl_p: command-decoded RAM behind an SPI slave | rev 1.0 ====
`default_nettype none

module spi_ram_ctrl_p #(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 8,
    parameter int MEM_DEPTH  = 256,
    parameter int AUTO_INC   = 1,
    parameter int RD_LAT     = 1,
    parameter int INIT_CLEAR = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W+1:0] din,
    input  logic              rx_valid,
    output logic [DATA_W-1:0] dout,
    output logic              tx_valid,
    output logic              busy,
    output logic              cmd_drop,
    output logic              wr_wrap,
    output logic              rd_wrap
);

    import spi_ram_pkg::*;

    localparam logic [ADDR_W-1:0] c_last      = ADDR_W'(MEM_DEPTH - 1);
    localparam logic [DATA_W:0]   c_depth     = (DATA_W+1)'(MEM_DEPTH);
    localparam state_e            c_rst_state = (INIT_CLEAR != 0) ? ST_INIT : ST_RUN;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic [ADDR_W-1:0] addr_wr_q, addr_wr_d;
    logic [ADDR_W-1:0] addr_rd_q, addr_rd_d;
    logic              cmd_drop_q, cmd_drop_d;
    logic              wr_wrap_q, wr_wrap_d;
    logic              rd_wrap_q, rd_wrap_d;
    logic              tx_valid_q, tx_valid_d;
    logic              rd_v1_q, clr_v1_q;

    cmd_e              w_cmd;
    logic [DATA_W-1:0] w_payload;
    logic              w_run, w_in_range, w_rd, w_nonrd, w_set, w_clr;
    logic              w_we;
    logic [ADDR_W-1:0] w_waddr;
    logic [DATA_W-1:0] w_wdata;
    logic [DATA_W-1:0] w_rdata;

    assign w_cmd      = cmd_e'(din[DATA_W+1:DATA_W]);
    assign w_payload  = din[DATA_W-1:0];
    assign w_run      = (state_q == ST_RUN);
    assign w_in_range = ({1'b0, w_payload} < c_depth);
    assign w_rd       = w_run && rx_valid && (w_cmd == CMD_RD_DATA);
    assign w_nonrd    = w_run && rx_valid && (w_cmd != CMD_RD_DATA);

    // With two-cycle latency the clear is delayed as well, so a pending read is shown first.
    assign w_set = (RD_LAT == 2) ? rd_v1_q  : w_rd;
    assign w_clr = (RD_LAT == 2) ? clr_v1_q : w_nonrd;

    always_comb begin
        state_d    = state_q;
        clr_cnt_d  = clr_cnt_q;
        addr_wr_d  = addr_wr_q;
        addr_rd_d  = addr_rd_q;
        cmd_drop_d = 1'b0;
        wr_wrap_d  = 1'b0;
        rd_wrap_d  = 1'b0;
        w_we       = 1'b0;
        w_waddr    = addr_wr_q;
        w_wdata    = w_payload;
        tx_valid_d = w_set ? 1'b1 : (w_clr ? 1'b0 : tx_valid_q);

        case (state_q)
            ST_INIT: begin
                w_we       = 1'b1;
                w_waddr    = clr_cnt_q;
                w_wdata    = '0;
                cmd_drop_d = rx_valid;
                if (clr_cnt_q == c_last) begin
                    state_d = ST_RUN;
                end else begin
                    clr_cnt_d = clr_cnt_q + ADDR_W'(1);
                end
            end
            ST_RUN: begin
                if (rx_valid) begin
                    case (w_cmd)
                        CMD_WR_ADDR: begin
                            if (w_in_range) addr_wr_d = w_payload[ADDR_W-1:0];
                            else            cmd_drop_d = 1'b1;
                        end
                        CMD_WR_DATA: begin
                            w_we = 1'b1;
                            if (AUTO_INC != 0) begin
                                addr_wr_d = ADDR_W'(next_addr(32'(addr_wr_q), MEM_DEPTH));
                                wr_wrap_d = (addr_wr_q == c_last);
                            end
                        end
                        CMD_RD_ADDR: begin
                            if (w_in_range) addr_rd_d = w_payload[ADDR_W-1:0];
                            else            cmd_drop_d = 1'b1;
                        end
                        CMD_RD_DATA: begin
                            if (AUTO_INC != 0) begin
                                addr_rd_d = ADDR_W'(next_addr(32'(addr_rd_q), MEM_DEPTH));
                                rd_wrap_d = (addr_rd_q == c_last);
                            end
                        end
                        default: ;
                    endcase
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= c_rst_state;
            clr_cnt_q  <= '0;
            addr_wr_q  <= '0;
            addr_rd_q  <= '0;
            cmd_drop_q <= 1'b0;
            wr_wrap_q  <= 1'b0;
            rd_wrap_q  <= 1'b0;
            tx_valid_q <= 1'b0;
            rd_v1_q    <= 1'b0;
            clr_v1_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            addr_wr_q  <= addr_wr_d;
            addr_rd_q  <= addr_rd_d;
            cmd_drop_q <= cmd_drop_d;
            wr_wrap_q  <= wr_wrap_d;
            rd_wrap_q  <= rd_wrap_d;
            tx_valid_q <= tx_valid_d;
            rd_v1_q    <= w_rd;
            clr_v1_q   <= w_nonrd;
        end
    end

    spi_ram_array #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .MEM_DEPTH (MEM_DEPTH)
    ) u_array (
        .clk     (clk),
        .we_i    (w_we),
        .waddr_i (w_waddr),
        .wdata_i (w_wdata),
        .re_i    (w_rd),
        .raddr_i (addr_rd_q),
        .rdata_o (w_rdata)
    );

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic [DATA_W-1:0] dout_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)       dout_q <= '0;
                else if (rd_v1_q) dout_q <= w_rdata;
            end
            assign dout = dout_q;
        end else begin : g_lat1
            // The array register has no reset, so its output is masked until the first read.
            logic rd_seen_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)    rd_seen_q <= 1'b0;
                else if (w_rd) rd_seen_q <= 1'b1;
            end
            assign dout = rd_seen_q ? w_rdata : '0;
        end
    endgenerate

    assign tx_valid = tx_valid_q;
    assign busy     = (state_q == ST_INIT);
    assign cmd_drop = cmd_drop_q;
    assign wr_wrap  = wr_wrap_q;
    assign rd_wrap  = rd_wrap_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_ram_ctrl_p.sv
// ==== tb_spi_ram_ctrl_p: scoreboard bench, DUT a = 256/RD_LAT1, DUT b = 200/RD_LAT2 | rev 1.0 ====
`default_nettype none

module tb_spi_ram_ctrl_p;

    typedef struct packed {
        int         cyc;
        logic       vld;
        logic [7:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] din   [2];
    logic       rxv   [2];
    logic [7:0] dout  [2];
    logic       txv   [2];
    logic       busy  [2];
    logic       drop  [2];
    logic       wwrap [2];
    logic       rwrap [2];

    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    exp_t q0 [$];
    exp_t q1 [$];
    exp_t ea, eb;
    int   nb, nd;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spi_ram_ctrl_p u_dut_a (
        .clk(clk), .rst_n(rst_n), .din(din[0]), .rx_valid(rxv[0]),
        .dout(dout[0]), .tx_valid(txv[0]), .busy(busy[0]), .cmd_drop(drop[0]),
        .wr_wrap(wwrap[0]), .rd_wrap(rwrap[0])
    );

    spi_ram_ctrl_p #(.MEM_DEPTH(200), .RD_LAT(2)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .din(din[1]), .rx_valid(rxv[1]),
        .dout(dout[1]), .tx_valid(txv[1]), .busy(busy[1]), .cmd_drop(drop[1]),
        .wr_wrap(wwrap[1]), .rd_wrap(rwrap[1])
    );

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] stat(input int d);
        return {3'd0, busy[d], txv[d], drop[d], wwrap[d], rwrap[d], dout[d]};
    endfunction

    // Issue one command; push the expected tx_valid/dout the monitor should see.
    task automatic send(input int d, input logic [1:0] c, input logic [7:0] p, input logic [7:0] x);
        exp_t e;
        din[d] = {c, p};
        rxv[d] = 1'b1;
        @(posedge clk);
        #1;
        rxv[d] = 1'b0;
        e.cyc  = cyc + ((d == 0) ? 0 : 1);
        e.vld  = (c == 2'b11);
        e.data = (c == 2'b11) ? x : 8'h00;
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Release reset and count busy cycles / cmd_drop pulses of DUT a.
    task automatic run_clear(input int hold, output int nbusy, output int ndrop);
        nbusy  = 0;
        ndrop  = 0;
        din[0] = {2'b11, 8'h00};
        rxv[0] = (hold > 0);
        rst_n  = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (busy[0]) nbusy++;
            if (drop[0]) ndrop++;
            if (i == hold) rxv[0] = 1'b0;
            if (!busy[0]) break;
        end
        rxv[0] = 1'b0;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin : mon_a
        if (q0.size() > 0 && q0[0].cyc == cyc) begin
            ea = q0.pop_front();
            chk(ea.vld ? "a_read" : "a_clear", {7'd0, txv[0], ea.vld ? dout[0] : 8'h00},
                {7'd0, ea.vld, ea.data});
        end
    end

    always @(negedge clk) begin : mon_b
        if (q1.size() > 0 && q1[0].cyc == cyc) begin
            eb = q1.pop_front();
            chk(eb.vld ? "b_read" : "b_clear", {7'd0, txv[1], eb.vld ? dout[1] : 8'h00},
                {7'd0, eb.vld, eb.data});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b1;
        for (int d = 0; d < 2; d++) begin
            din[d] = '0;
            rxv[d] = 1'b0;
        end
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("a_reset", stat(0), 16'h1000);
        chk("b_reset", stat(1), 16'h1000);

        // Clear sequence with commands arriving during the first 10 cycles
        run_clear(10, nb, nd);
        chk("a_busy_cycles", 16'(nb), 16'd256);
        chk("a_init_drops", 16'(nd), 16'd10);
        chk("a_tx_after_init", {15'd0, txv[0]}, 16'd0);
        send(0, 2'b10, 8'h00, 8'h00);
        send(0, 2'b11, 8'h00, 8'h00);
        send(0, 2'b10, 8'hFF, 8'h00);
        send(0, 2'b11, 8'h00, 8'h00);

        // Write then read, with hold while idle
        send(0, 2'b00, 8'h12, 8'h00);
        send(0, 2'b01, 8'hA5, 8'h00);
        send(0, 2'b10, 8'h12, 8'h00);
        send(0, 2'b11, 8'h00, 8'hA5);
        idle(3);
        chk("a_hold", {7'd0, txv[0], dout[0]}, 16'h01A5);
        send(1, 2'b00, 8'h12, 8'h00);
        send(1, 2'b01, 8'hA5, 8'h00);
        send(1, 2'b10, 8'h12, 8'h00);
        send(1, 2'b11, 8'h00, 8'hA5);
        idle(3);
        chk("b_hold", {7'd0, txv[1], dout[1]}, 16'h01A5);

        // Auto-increment wrap on a 256-word memory
        send(0, 2'b00, 8'hFE, 8'h00);
        send(0, 2'b01, 8'h11, 8'h00);
        chk("a_wwrap_1", {15'd0, wwrap[0]}, 16'd0);
        send(0, 2'b01, 8'h22, 8'h00);
        chk("a_wwrap_2", {15'd0, wwrap[0]}, 16'd1);
        send(0, 2'b01, 8'h33, 8'h00);
        chk("a_wwrap_3", {15'd0, wwrap[0]}, 16'd0);
        send(0, 2'b10, 8'hFE, 8'h00);
        send(0, 2'b11, 8'h00, 8'h11);
        chk("a_rwrap_1", {15'd0, rwrap[0]}, 16'd0);
        send(0, 2'b11, 8'h00, 8'h22);
        chk("a_rwrap_2", {15'd0, rwrap[0]}, 16'd1);
        send(0, 2'b11, 8'h00, 8'h33);
        chk("a_rwrap_3", {15'd0, rwrap[0]}, 16'd0);
        send(0, 2'b00, 8'hC8, 8'h00);
        chk("a_c8_accepted", {15'd0, drop[0]}, 16'd0);

        // Range check on a 200-word memory
        send(1, 2'b00, 8'h05, 8'h00);
        chk("b_drop_in_range", {15'd0, drop[1]}, 16'd0);
        send(1, 2'b00, 8'hC8, 8'h00);
        chk("b_drop_wr_c8", {15'd0, drop[1]}, 16'd1);
        send(1, 2'b01, 8'h77, 8'h00);
        send(1, 2'b10, 8'h05, 8'h00);
        send(1, 2'b10, 8'hC8, 8'h00);
        chk("b_drop_rd_c8", {15'd0, drop[1]}, 16'd1);
        send(1, 2'b11, 8'h00, 8'h77);

        // Back-to-back reads with two-cycle latency
        send(1, 2'b00, 8'h00, 8'h00);
        send(1, 2'b01, 8'hA0, 8'h00);
        send(1, 2'b01, 8'hA1, 8'h00);
        send(1, 2'b01, 8'hA2, 8'h00);
        send(1, 2'b01, 8'hA3, 8'h00);
        send(1, 2'b10, 8'h00, 8'h00);
        send(1, 2'b11, 8'h00, 8'hA0);
        send(1, 2'b11, 8'h00, 8'hA1);
        send(1, 2'b11, 8'h00, 8'hA2);
        send(1, 2'b11, 8'h00, 8'hA3);
        send(1, 2'b00, 8'h10, 8'h00);
        send(1, 2'b11, 8'h00, 8'h00);
        idle(2);

        // Reset between a read command and its two-cycle output
        din[1] = {2'b11, 8'h00};
        rxv[1] = 1'b1;
        @(posedge clk);
        #1;
        rxv[1] = 1'b0;
        rst_n  = 1'b0;
        #1;
        chk("a_reset_midread", stat(0), 16'h1000);
        chk("b_reset_midread", stat(1), 16'h1000);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("b_no_stale_tx", {7'd0, txv[1], dout[1]}, 16'h0000);
        end

        // Reset in the middle of the clear; clear must restart from word 0
        idle(50);
        chk("a_busy_midclear", {15'd0, busy[0]}, 16'd1);
        rst_n = 1'b0;
        #1;
        chk("a_reset_midclear", stat(0), 16'h1000);
        @(posedge clk);
        #1;
        run_clear(0, nb, nd);
        chk("a_busy_restart", 16'(nb), 16'd256);
        chk("a_drops_restart", 16'(nd), 16'd0);
        send(0, 2'b10, 8'h12, 8'h00);
        send(0, 2'b11, 8'h00, 8'h00);
        send(1, 2'b10, 8'h05, 8'h00);
        send(1, 2'b11, 8'h00, 8'h00);
        idle(4);

        chk("a_queue_drained", 16'(q0.size()), 16'd0);
        chk("b_queue_drained", 16'(q1.size()), 16'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
